issue_scoreboard: RTL and testbench

//   Issue controller sitting between the instruction field extractor and the execute stage.

---
 rtl/issue_scoreboard.sv | 66 ++++++
 tb/tb_issue_scoreboard.sv | 95 +++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: RAW/WAW issue control with per-register pending counters and a one-entry execute register
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ADDR_W-1:0]   id_rd,
  input  logic [ADDR_W-1:0]   id_rs1,
  input  logic [ADDR_W-1:0]   id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic                id_writes_rd,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ADDR_W-1:0]   ex_rd,
  output logic                ex_writes_rd,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [31:0]         stall_count,
  output logic                err_underflow
);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic wb_hit, busy1, busy2, full_rd, hazard, fire, inc;
  assign wb_hit  = wb_valid && wb_rd != '0 && cnt[wb_rd] != '0;
  assign busy1   = id_uses_rs1 && id_rs1 != '0 && cnt[id_rs1] != CNT_W'(wb_hit && wb_rd == id_rs1);
  assign busy2   = id_uses_rs2 && id_rs2 != '0 && cnt[id_rs2] != CNT_W'(wb_hit && wb_rd == id_rs2);
  assign full_rd = id_writes_rd && id_rd != '0 && cnt[id_rd] == MAX;
  assign hazard  = busy1 || busy2 || full_rd;
  assign id_ready = !reset && !flush && !hazard && (!ex_valid || ex_ready);
  assign fire    = id_valid && id_ready;
  assign inc     = fire && id_writes_rd && id_rd != '0;
  always_comb begin
    busy_mask = '0;
    for (int r = 1; r < NUM_REGS; r++) busy_mask[r] = cnt[r] != '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_writes_rd  <= 1'b0;
      stall_count   <= '0;
      err_underflow <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      ex_valid <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= cnt[r] + CNT_W'(inc && id_rd == ADDR_W'(r)) - CNT_W'(wb_hit && wb_rd == ADDR_W'(r));
      ex_valid <= fire || (ex_valid && !ex_ready);
      if (fire) begin
        ex_rd        <= id_rd;
        ex_writes_rd <= id_writes_rd && id_rd != '0;
      end
      stall_count   <= stall_count + 32'(id_valid && !id_ready && stall_count != '1);
      err_underflow <= err_underflow || (wb_valid && wb_rd != '0 && cnt[wb_rd] == '0);
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: directed scenarios plus random traffic against a counter-array reference model
module tb_issue_scoreboard;
  logic clk = 1'b0;
  logic reset, flush, id_valid, id_ready, id_uses_rs1, id_uses_rs2, id_writes_rd;
  logic ex_valid, ex_ready, ex_writes_rd, wb_valid, err_underflow;
  logic [4:0] id_rd, id_rs1, id_rs2, ex_rd, wb_rd;
  logic [31:0] busy_mask, stall_count;
  int checks = 0, failures = 0;
  int cnt_m [32];
  bit exv_m, exw_m, err_m;
  bit [4:0] exrd_m;
  bit [31:0] stall_m;
  always #5 clk = ~clk;
  issue_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .id_writes_rd(id_writes_rd), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_writes_rd(ex_writes_rd), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .busy_mask(busy_mask), .stall_count(stall_count), .err_underflow(err_underflow)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input bit r, f, v, input bit [4:0] rd, s1, s2, input bit u1, u2, w, er, wv, input bit [4:0] wrd);
    int eff1, eff2;
    bit rdy, fire;
    bit [31:0] busy;
    reset = r; flush = f; id_valid = v; id_rd = rd; id_rs1 = s1; id_rs2 = s2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_writes_rd = w; ex_ready = er; wb_valid = wv; wb_rd = wrd;
    #1;
    eff1 = cnt_m[s1] - ((wv && wrd == s1 && wrd != 0 && cnt_m[s1] > 0) ? 1 : 0);
    eff2 = cnt_m[s2] - ((wv && wrd == s2 && wrd != 0 && cnt_m[s2] > 0) ? 1 : 0);
    rdy = !r && !f && (!exv_m || er)
        && !(u1 && s1 != 0 && eff1 > 0) && !(u2 && s2 != 0 && eff2 > 0) && !(w && rd != 0 && cnt_m[rd] >= 3);
    check("id_ready", id_ready, rdy);
    fire = v && rdy;
    if (r) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      exv_m = 0; exw_m = 0; exrd_m = 0; stall_m = 0; err_m = 0;
    end else if (f) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      exv_m = 0;
    end else begin
      if (v && !rdy && stall_m != 32'hFFFF_FFFF) stall_m++;
      if (wv && wrd != 0) begin
        if (cnt_m[wrd] == 0) err_m = 1;
        else cnt_m[wrd]--;
      end
      if (fire && w && rd != 0) cnt_m[rd]++;
      exv_m = fire || (exv_m && !er);
      if (fire) begin exrd_m = rd; exw_m = w && rd != 0; end
    end
    @(posedge clk);
    @(negedge clk);
    busy = '0;
    for (int i = 1; i < 32; i++) busy[i] = cnt_m[i] != 0;
    check("ex_valid", ex_valid, exv_m);
    check("ex_rd", ex_rd, exrd_m);
    check("ex_writes_rd", ex_writes_rd, exw_m);
    check("busy_mask", busy_mask, busy);
    check("stall_count", stall_count, stall_m);
    check("err_underflow", err_underflow, err_m);
  endtask
  initial begin
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 5, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (3) cyc(0, 0, 1, 6, 5, 0, 1, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 6, 5, 0, 1, 0, 1, 1, 1, 5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6);
    repeat (3) cyc(0, 0, 1, 7, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (2) cyc(0, 0, 1, 7, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 7, 0, 0, 0, 0, 1, 1, 1, 7);
    repeat (4) cyc(0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0);
    cyc(0, 0, 1, 8, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (4) cyc(0, 0, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 9, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 1, 3, 0, 0, 0, 0, 1, 1, 0, 0);
    cyc(0, 1, 1, 4, 0, 0, 0, 0, 1, 1, 1, 3);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 12);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 1, 5, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int n = 0; n < 3000; n++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
